// File: rtl/ex_fwd_if.sv
// Execute-stage bus: EX operands and controls in, EX/DM and DM/WB registers out.
interface ex_fwd_if #(
  parameter int DW = 32
);
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic [15:0]   imm;
  logic [5:0]    op_dec;
  logic [1:0]    mux_sel_A;
  logic [1:0]    mux_sel_B;
  logic          imm_sel;
  logic          mem_en_ex;
  logic          mem_rw_ex;
  logic          mem_mux_sel_dm;
  logic [DW-1:0] dm_rdata;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_en;
  logic          dm_rw;
  logic [DW-1:0] wb_data;
  logic          ex_zero;
  logic          ex_ovf;

  modport master (
    output rf_a, rf_b, imm, op_dec,
    output mux_sel_A, mux_sel_B, imm_sel,
    output mem_en_ex, mem_rw_ex,
    output mem_mux_sel_dm, dm_rdata,
    input  dm_addr, dm_wdata, dm_en, dm_rw,
    input  wb_data, ex_zero, ex_ovf
  );

  modport slave (
    input  rf_a, rf_b, imm, op_dec,
    input  mux_sel_A, mux_sel_B, imm_sel,
    input  mem_en_ex, mem_rw_ex,
    input  mem_mux_sel_dm, dm_rdata,
    output dm_addr, dm_wdata, dm_en, dm_rw,
    output wb_data, ex_zero, ex_ovf
  );
endinterface

// File: rtl/ex_fwd_stage.sv
// Execute stage: operand forwarding, immediate mux, ALU,
// EX/DM register bank and DM/WB result register.
module ex_fwd_stage #(
  parameter int DW  = 32,
  parameter int SHW = 5
) (
  input logic    clk,
  input logic    reset,
  ex_fwd_if.slave bus
);
  logic [DW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic          dm_en_q, dm_en_d;
  logic          dm_rw_q, dm_rw_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          ex_zero_q, ex_zero_d;
  logic          ex_ovf_q, ex_ovf_d;

  logic [DW-1:0] fwd_a, fwd_b, opb, res;
  logic [2:0]    fn;
  logic          unused_op;

  assign fn        = bus.op_dec[2:0];
  assign unused_op = ^bus.op_dec[5:3];

  // 01 = previous instr (EX/DM), 10 = instr before that (DM/WB)
  always_comb begin
    fwd_a = bus.rf_a;
    case (bus.mux_sel_A)
      2'b01:   fwd_a = dm_addr_q;
      2'b10:   fwd_a = wb_data_q;
      default: fwd_a = bus.rf_a;
    endcase
  end

  always_comb begin
    fwd_b = bus.rf_b;
    case (bus.mux_sel_B)
      2'b01:   fwd_b = dm_addr_q;
      2'b10:   fwd_b = wb_data_q;
      default: fwd_b = bus.rf_b;
    endcase
  end

  assign opb = bus.imm_sel
             ? {{(DW-16){bus.imm[15]}}, bus.imm}
             : fwd_b;

  always_comb begin
    res      = '0;
    ex_ovf_d = 1'b0;
    case (fn)
      3'b000: begin
        res      = fwd_a + opb;
        ex_ovf_d = (fwd_a[DW-1] == opb[DW-1])
                && (res[DW-1] != fwd_a[DW-1]);
      end
      3'b001: begin
        res      = fwd_a - opb;
        ex_ovf_d = (fwd_a[DW-1] != opb[DW-1])
                && (res[DW-1] != fwd_a[DW-1]);
      end
      3'b010: res = fwd_a & opb;
      3'b011: res = fwd_a | opb;
      3'b100: res = fwd_a ^ opb;
      3'b101: res = fwd_a << opb[SHW-1:0];
      3'b110: res = fwd_a >> opb[SHW-1:0];
      default: res = {{(DW-1){1'b0}},
                      ($signed(fwd_a) < $signed(opb))};
    endcase
  end

  always_comb begin
    dm_addr_d  = res;
    dm_wdata_d = fwd_b;
    dm_en_d    = bus.mem_en_ex;
    dm_rw_d    = bus.mem_rw_ex;
    ex_zero_d  = (res == '0);
    wb_data_d  = bus.mem_mux_sel_dm ? bus.dm_rdata : dm_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_en_q    <= 1'b0;
      dm_rw_q    <= 1'b0;
      wb_data_q  <= '0;
      ex_zero_q  <= 1'b0;
      ex_ovf_q   <= 1'b0;
    end else begin
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_en_q    <= dm_en_d;
      dm_rw_q    <= dm_rw_d;
      wb_data_q  <= wb_data_d;
      ex_zero_q  <= ex_zero_d;
      ex_ovf_q   <= ex_ovf_d;
    end
  end

  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;
  assign bus.dm_en    = dm_en_q;
  assign bus.dm_rw    = dm_rw_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.ex_zero  = ex_zero_q;
  assign bus.ex_ovf   = ex_ovf_q;
endmodule

// File: tb/tb_ex_fwd_stage.sv
// Bench for ex_fwd_stage: directed scenarios plus a random ALU sweep,
// expected values queued at issue and popped after the capturing edge.
module tb_ex_fwd_stage;
  localparam int DW = 32;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] OR_ = 3'd3;
  localparam logic [2:0] SLT = 3'd7;

  logic clk = 1'b0;
  logic reset;

  ex_fwd_if #(.DW(DW)) bus();

  ex_fwd_stage #(.DW(DW), .SHW(5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        rw;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int checks = 0;
  int passed = 0;

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im, input logic [2:0] op,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic isel, input logic en,
                       input logic rw);
    bus.rf_a      = a;
    bus.rf_b      = b;
    bus.imm       = im;
    bus.op_dec    = {3'b101, op};
    bus.mux_sel_A = sa;
    bus.mux_sel_B = sb;
    bus.imm_sel   = isel;
    bus.mem_en_ex = en;
    bus.mem_rw_ex = rw;
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] wd,
                      input logic en, input logic rw, input logic ovf);
    exp_t x;
    x.addr  = addr;
    x.wdata = wd;
    x.en    = en;
    x.rw    = rw;
    x.zero  = (addr == 32'd0);
    x.ovf   = ovf;
    sbq.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.mem_mux_sel_dm = 1'b0;
    bus.dm_rdata = 32'h0;
    drive(32'h11, 32'h22, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    tick;
    checks++;
    if ({bus.dm_addr, bus.dm_wdata, bus.wb_data, bus.dm_en, bus.dm_rw,
         bus.ex_zero, bus.ex_ovf} !== 100'd0)
      $display("FAIL reset_state addr=%h wd=%h wb=%h en=%b rw=%b z=%b o=%b exp all 0",
               bus.dm_addr, bus.dm_wdata, bus.wb_data, bus.dm_en,
               bus.dm_rw, bus.ex_zero, bus.ex_ovf);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid;
    drive(32'h40, 32'h9, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    tick;
    checks++;
    if (bus.dm_en !== 1'b1 || bus.dm_addr !== 32'h49)
      $display("FAIL pre_reset_store en=%b addr=%h exp 1/49",
               bus.dm_en, bus.dm_addr);
    else passed++;
    tick;
    reset = 1'b1;
    tick;
    checks++;
    if ({bus.dm_addr, bus.dm_wdata, bus.wb_data, bus.dm_en, bus.dm_rw,
         bus.ex_zero, bus.ex_ovf} !== 100'd0)
      $display("FAIL mid_reset addr=%h wd=%h wb=%h en=%b rw=%b exp all 0",
               bus.dm_addr, bus.dm_wdata, bus.wb_data, bus.dm_en, bus.dm_rw);
    else passed++;
    reset = 1'b0;
    tick;
    checks++;
    if (bus.dm_en !== 1'b1 || bus.dm_rw !== 1'b1)
      $display("FAIL post_reset_en en=%b rw=%b exp 1/1", bus.dm_en, bus.dm_rw);
    else passed++;
  endtask

  task automatic test_back_to_back;
    drive(32'd5, 32'd7, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'd12, 32'd7, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr)
      $display("FAIL b2b_add dm_addr got %h exp %h", bus.dm_addr, e.addr);
    else passed++;
    drive(32'd99, 32'd3, 16'h0, SUB, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr)
      $display("FAIL b2b_sub dm_addr got %h exp %h", bus.dm_addr, e.addr);
    else passed++;
    checks++;
    if (bus.wb_data !== 32'd12)
      $display("FAIL b2b_wb wb_data got %h exp 0000000c", bus.wb_data);
    else passed++;
  endtask

  task automatic test_load_fwd;
    drive(32'h10, 32'h0, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr || bus.dm_en !== e.en || bus.dm_rw !== e.rw)
      $display("FAIL load_issue addr=%h en=%b rw=%b exp %h/%b/%b",
               bus.dm_addr, bus.dm_en, bus.dm_rw, e.addr, e.en, e.rw);
    else passed++;
    bus.mem_mux_sel_dm = 1'b1;
    bus.dm_rdata = 32'hCAFE;
    drive(32'h0, 32'h0, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.wb_data !== 32'hCAFE || bus.dm_en !== e.en)
      $display("FAIL load_wb wb_data=%h en=%b exp 0000cafe/%b",
               bus.wb_data, bus.dm_en, e.en);
    else passed++;
    bus.mem_mux_sel_dm = 1'b0;
    bus.dm_rdata = 32'hDEAD;
    drive(32'd1, 32'h999, 16'h0, ADD, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0);
    push(32'hCAFF, 32'hCAFE, 1'b1, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr || bus.dm_wdata !== e.wdata)
      $display("FAIL load_fwd2 addr=%h wd=%h exp %h/%h",
               bus.dm_addr, bus.dm_wdata, e.addr, e.wdata);
    else passed++;
    // load whose DM cycle selects the ALU path: wb takes the address
    drive(32'h0, 32'h0, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    checks++;
    if (bus.wb_data !== 32'hCAFF)
      $display("FAIL load_addr_wb wb_data=%h exp 0000caff", bus.wb_data);
    else passed++;
  endtask

  task automatic test_store;
    drive(32'h55, 32'h0, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'h55, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr)
      $display("FAIL store_src addr=%h exp %h", bus.dm_addr, e.addr);
    else passed++;
    drive(32'h20, 32'h777, 16'hFFFC, ADD, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1);
    push(32'h1C, 32'h55, 1'b1, 1'b1, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr || bus.dm_wdata !== e.wdata ||
        bus.dm_en !== e.en || bus.dm_rw !== e.rw)
      $display("FAIL store addr=%h wd=%h en=%b rw=%b exp %h/%h/%b/%b",
               bus.dm_addr, bus.dm_wdata, bus.dm_en, bus.dm_rw,
               e.addr, e.wdata, e.en, e.rw);
    else passed++;
  endtask

  task automatic test_flags;
    drive(32'h7FFFFFFF, 32'd1, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'h80000000, 32'd1, 1'b0, 1'b0, 1'b1);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.ex_ovf !== e.ovf || bus.ex_zero !== e.zero || bus.dm_addr !== e.addr)
      $display("FAIL add_ovf ovf=%b zero=%b addr=%h exp %b/%b/%h",
               bus.ex_ovf, bus.ex_zero, bus.dm_addr, e.ovf, e.zero, e.addr);
    else passed++;
    drive(32'd4, 32'd4, 16'h0, SUB, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'd0, 32'd4, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.ex_ovf !== e.ovf || bus.ex_zero !== e.zero)
      $display("FAIL sub_zero ovf=%b zero=%b exp %b/%b",
               bus.ex_ovf, bus.ex_zero, e.ovf, e.zero);
    else passed++;
    drive(32'hFFFFFFFF, 32'd1, 16'h0, SLT, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr)
      $display("FAIL slt dm_addr got %h exp %h", bus.dm_addr, e.addr);
    else passed++;
  endtask

  task automatic test_same_src;
    drive(32'h1234, 32'h1, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    drive(32'h0, 32'h0, 16'h0, ADD, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    push(32'h246A, 32'h1235, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr || bus.dm_wdata !== e.wdata)
      $display("FAIL same_src01 addr=%h wd=%h exp %h/%h",
               bus.dm_addr, bus.dm_wdata, e.addr, e.wdata);
    else passed++;
    drive(32'h0, 32'h0, 16'h0, SUB, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    push(32'h1235, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr)
      $display("FAIL same_src10 addr=%h exp %h", bus.dm_addr, e.addr);
    else passed++;
  endtask

  task automatic test_reserved;
    drive(32'h100, 32'h0, 16'h0, ADD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    drive(32'd2, 32'd3, 16'h0, OR_, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    push(32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    tick;
    e = sbq.pop_front();
    checks++;
    if (bus.dm_addr !== e.addr || bus.dm_wdata !== e.wdata)
      $display("FAIL reserved_sel addr=%h wd=%h exp %h/%h",
               bus.dm_addr, bus.dm_wdata, e.addr, e.wdata);
    else passed++;
  endtask

  task automatic test_alu_sweep;
    logic [31:0] a, b, ob, r, prev;
    logic [15:0] im;
    logic [2:0]  op;
    logic        isel, o;
    prev = bus.dm_addr;
    for (int i = 0; i < 32; i++) begin
      op   = 3'(i % 8);
      a    = $urandom;
      b    = $urandom;
      im   = 16'($urandom);
      isel = (i >= 16) && (i % 2 == 0);
      ob   = isel ? {{16{im[15]}}, im} : b;
      o    = 1'b0;
      case (op)
        3'd0: begin r = a + ob; o = (a[31] == ob[31]) && (r[31] != a[31]); end
        3'd1: begin r = a - ob; o = (a[31] != ob[31]) && (r[31] != a[31]); end
        3'd2: r = a & ob;
        3'd3: r = a | ob;
        3'd4: r = a ^ ob;
        3'd5: r = a << ob[4:0];
        3'd6: r = a >> ob[4:0];
        default: r = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
      endcase
      drive(a, b, im, op, 2'b00, 2'b00, isel, 1'b0, 1'b0);
      push(r, b, 1'b0, 1'b0, o);
      tick;
      e = sbq.pop_front();
      checks++;
      if (bus.dm_addr !== e.addr || bus.ex_zero !== e.zero ||
          bus.ex_ovf !== e.ovf || bus.dm_wdata !== e.wdata)
        $display("FAIL alu_op%0d i=%0d addr=%h z=%b o=%b wd=%h exp %h/%b/%b/%h",
                 op, i, bus.dm_addr, bus.ex_zero, bus.ex_ovf, bus.dm_wdata,
                 e.addr, e.zero, e.ovf, e.wdata);
      else passed++;
      checks++;
      if (bus.wb_data !== prev)
        $display("FAIL alu_wb i=%0d wb_data=%h exp %h", i, bus.wb_data, prev);
      else passed++;
      prev = e.addr;
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_back_to_back;
    test_load_fwd;
    test_store;
    test_flags;
    test_same_src;
    test_reserved;
    test_alu_sweep;
    checks++;
    if (sbq.size() != 0)
      $display("FAIL scoreboard_drain left=%0d exp 0", sbq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
